// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling-floor / energy-bar plotter.
package scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERASE = 2'd3
    } scroll_state_t;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_YELLOW = 3'b110;

    localparam int unsigned TICK_DIV_50MHZ_16HZ = 3_125_000;

endpackage

// File: rtl/scroll_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick TICK_DIV clocks after reset.
module scroll_tick_gen
    import scroll_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_50MHZ_16HZ
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/scroll_stripe_plotter.sv
// Dashed scrolling rows plus an energy bar that loses one column every BAR_STEP_TICKS ticks.
// Sole pixel-write source for the 160x120 VGA adapter while enabled.
module scroll_stripe_plotter
    import scroll_pkg::*;
#(
    parameter int unsigned SCREEN_W       = 160,
    parameter int unsigned X_W            = 8,
    parameter int unsigned Y_W            = 7,
    parameter int unsigned NUM_ROWS       = 1,
    parameter int unsigned ROW_Y0         = 79,
    parameter int unsigned ROW_STEP       = 1,
    parameter int unsigned ROW_SKEW       = 0,
    parameter int unsigned PERIOD         = 16,
    parameter int unsigned ON_LEN         = 8,
    parameter logic [2:0]  COLOR_ON       = COLOR_YELLOW,
    parameter logic [2:0]  COLOR_OFF      = COLOR_BLACK,
    parameter int unsigned TICK_DIV       = TICK_DIV_50MHZ_16HZ,
    parameter int unsigned BAR_W          = 160,
    parameter int unsigned BAR_H          = 5,
    parameter int unsigned BAR_Y          = 0,
    parameter int unsigned BAR_STEP_TICKS = 16
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           enable,
    input  logic           dir,
    input  logic           refill,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic [X_W-1:0] bar_level,
    output logic           bar_empty,
    output logic           busy
);

    localparam int unsigned P_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned R_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned E_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;
    localparam int unsigned T_W = $clog2(BAR_STEP_TICKS + 1);

    scroll_state_t  state, state_n;
    logic [R_W-1:0] row, row_n;
    logic [E_W-1:0] ecnt, ecnt_n;
    logic [P_W-1:0] phase, phase_n;
    logic [T_W-1:0] tick_cnt, tick_cnt_n;
    logic           pending, pending_n;
    logic [X_W-1:0] x_n, bar_level_n;
    logic [Y_W-1:0] y_n;
    logic [2:0]     colour_n;
    logic           plot_n, bar_empty_n, busy_n;
    logic           start_draw;
    logic           tick;

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .tick    (tick)
    );

    function automatic logic [Y_W-1:0] row_y(input logic [R_W-1:0] r);
        return Y_W'(ROW_Y0 + 32'(r) * ROW_STEP);
    endfunction

    function automatic logic [2:0] pix_colour(input logic [X_W-1:0] px,
                                              input logic [R_W-1:0] pr,
                                              input logic [P_W-1:0] ph);
        int unsigned p;
        p = (32'(px) + 32'(ph) + 32'(pr) * ROW_SKEW) % PERIOD;
        return (p < ON_LEN) ? COLOR_ON : COLOR_OFF;
    endfunction

    // Next-state and next-output logic; every transition into DRAW presents pixel (0, row 0).
    always_comb begin
        state_n     = state;
        row_n       = row;
        ecnt_n      = ecnt;
        phase_n     = phase;
        tick_cnt_n  = tick_cnt;
        pending_n   = pending | tick;
        x_n         = x;
        y_n         = y;
        colour_n    = colour;
        plot_n      = 1'b0;
        bar_level_n = bar_level;
        start_draw  = 1'b0;

        case (state)
            ST_IDLE: begin
                phase_n    = '0;
                tick_cnt_n = '0;
                start_draw = enable;
            end
            ST_DRAW: begin
                if (x == X_W'(SCREEN_W - 1)) begin
                    if (row == R_W'(NUM_ROWS - 1)) begin
                        state_n = ST_WAIT;
                    end else begin
                        row_n  = row + R_W'(1);
                        x_n    = '0;
                        plot_n = 1'b1;
                    end
                end else begin
                    x_n    = x + X_W'(1);
                    plot_n = 1'b1;
                end
                if (plot_n) begin
                    y_n      = row_y(row_n);
                    colour_n = pix_colour(x_n, row_n, phase);
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (pending) begin
                    // A tick landing on the service cycle is dropped, not queued.
                    pending_n  = 1'b0;
                    phase_n    = dir ? P_W'((32'(phase) + PERIOD - 1) % PERIOD)
                                     : P_W'((32'(phase) + 1) % PERIOD);
                    tick_cnt_n = tick_cnt + T_W'(1);
                    if (tick_cnt_n == T_W'(BAR_STEP_TICKS) && !bar_empty) begin
                        tick_cnt_n = '0;
                        state_n    = ST_ERASE;
                        ecnt_n     = '0;
                        x_n        = bar_level;
                        y_n        = Y_W'(BAR_Y);
                        colour_n   = COLOR_OFF;
                        plot_n     = 1'b1;
                    end else begin
                        if (tick_cnt_n == T_W'(BAR_STEP_TICKS)) begin
                            tick_cnt_n = '0;
                        end
                        start_draw = 1'b1;
                    end
                end
            end
            ST_ERASE: begin
                if (ecnt == E_W'(BAR_H - 1)) begin
                    bar_level_n = bar_level + X_W'(1);
                    start_draw  = 1'b1;
                end else begin
                    ecnt_n   = ecnt + E_W'(1);
                    y_n      = y + Y_W'(1);
                    colour_n = COLOR_OFF;
                    plot_n   = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (start_draw) begin
            state_n  = ST_DRAW;
            row_n    = '0;
            x_n      = '0;
            y_n      = row_y('0);
            colour_n = pix_colour('0, '0, phase_n);
            plot_n   = 1'b1;
        end

        if (refill) begin
            bar_level_n = '0;
        end

        bar_empty_n = (bar_level_n == X_W'(BAR_W));
        busy_n      = (state_n == ST_DRAW) || (state_n == ST_ERASE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            row       <= '0;
            ecnt      <= '0;
            phase     <= '0;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            bar_level <= '0;
            bar_empty <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            ecnt      <= ecnt_n;
            phase     <= phase_n;
            tick_cnt  <= tick_cnt_n;
            pending   <= pending_n;
            x         <= x_n;
            y         <= y_n;
            colour    <= colour_n;
            plot      <= plot_n;
            bar_level <= bar_level_n;
            bar_empty <= bar_empty_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: doc/scroll_stripe_plotter.md
# scroll_stripe_plotter

- Parametrised scrolling-floor and energy-bar plotter that drives the pixel-write port (x, y, colour, plot) of the 160x120 VGA adapter.
- Redraws NUM_ROWS horizontal dashed rows once per scroll tick, advancing the dash phase left or right.
- Erases one energy-bar column every BAR_STEP_TICKS ticks until the bar is empty.
- Sits between the game top level and vga_adapter; it is the sole plot source while enabled.

## Interface
Parameters:
- SCREEN_W, 160, pixels per row (x range 0..SCREEN_W-1)
- X_W, 8, x width; Y_W, 7, y width
- NUM_ROWS, 1, dashed rows drawn per pass
- ROW_Y0, 79, y of row 0; ROW_STEP, 1, y increment per row
- ROW_SKEW, 0, phase offset added per row index (mod PERIOD)
- PERIOD, 16, dash period in pixels; ON_LEN, 8, lit pixels per period (1..PERIOD-1)
- COLOR_ON, 3'b110; COLOR_OFF, 3'b000
- TICK_DIV, 3_125_000, clocks per scroll tick (0.0625 s at 50 MHz)
- BAR_W, 160, energy bar columns; BAR_H, 5, bar rows starting at BAR_Y, 0
- BAR_STEP_TICKS, 16, ticks per erased column

Ports:
- CLOCK_50  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset (sampled on CLOCK_50)
- enable  in  1  run request
- dir  in  1  0 = scroll left, 1 = scroll right; sampled only at tick service
- refill  in  1  one-cycle pulse: bar_level <= 0 (bar full again)
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  write strobe
- bar_level  out  X_W  columns erased so far (0..BAR_W)
- bar_empty  out  1  bar_level == BAR_W
- busy  out  1  state is DRAW or ERASE

## Operation
- States: IDLE, DRAW, WAIT, ERASE.
- IDLE:
  - With enable = 1, go to DRAW.
  - phase = 0, tick_cnt = 0.
- DRAW:
  - One pixel per cycle, row-major: row r = 0..NUM_ROWS-1, x = 0..SCREEN_W-1.
  - y = ROW_Y0 + r*ROW_STEP.
  - p = (x + phase + r*ROW_SKEW) mod PERIOD.
  - colour = COLOR_ON if p < ON_LEN, else COLOR_OFF.
  - After the last pixel, go to WAIT.
- WAIT:
  - plot = 0.
  - If enable = 0, go to IDLE.
  - If tick_pending = 1:
    - Clear tick_pending.
    - Advance phase: dir 0 gives phase+1 mod PERIOD; dir 1 gives phase+PERIOD-1 mod PERIOD.
    - tick_cnt++.
    - If tick_cnt reaches BAR_STEP_TICKS: set tick_cnt = 0. If bar_empty = 0, go to ERASE; otherwise go to DRAW.
    - Otherwise, go to DRAW.
- ERASE:
  - BAR_H cycles plotting COLOR_OFF at x = bar_level, y = BAR_Y..BAR_Y+BAR_H-1.
  - Then bar_level++ and go to DRAW.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1 while not in reset.
  - Each wrap sets tick_pending.
  - Ticks arriving while tick_pending = 1 are dropped; ticks never queue.
- enable deasserted during DRAW or ERASE: the pass completes, then WAIT goes to IDLE.
- refill:
  - Clears bar_level immediately.
  - Does not abort an ERASE in progress; that ERASE's final increment still applies.
  - If refill and the final increment land in the same cycle, refill wins (bar_level = 0).
- Arithmetic:
  - Phase math uses a $clog2(PERIOD)-bit register.
  - Row y math uses Y_W bits and wraps silently; parameter legality is the integrator's job.

## Timing
- Reset (resetn = 0 at an edge) forces on the next edge:
  - x = 0, y = 0, colour = 0, plot = 0
  - bar_level = 0, bar_empty = 0, busy = 0
  - state = IDLE, phase = 0, tick counter = 0, tick_pending = 0
- Reset mid-pass abandons the pass; plot is 0 on the following edge.
- All outputs are registered.
- The edge that moves the state into DRAW also presents pixel (x=0, row 0) with plot = 1.
- plot stays high for exactly NUM_ROWS*SCREEN_W consecutive cycles per DRAW pass.
- In ERASE, plot stays high for exactly BAR_H consecutive cycles.
- WAIT to DRAW takes 1 cycle after tick_pending is observed.
- First tick after reset release occurs TICK_DIV cycles later.

## Structure
- Shared package scroll_pkg holds:
  - state encoding (IDLE/DRAW/WAIT/ERASE)
  - colour constants COLOR_BLACK = 3'b000 and COLOR_YELLOW = 3'b110
  - default TICK_DIV_50MHZ_16HZ = 3_125_000
- Sub-module scroll_tick_gen (parameter TICK_DIV; ports CLOCK_50, resetn, tick) replaces the old fixed delay divider.
- The pixel walker and FSM stay in the top block.

## Test plan
- Defaults with TICK_DIV = 400, enable = 1:
  - First pass: plot high for 160 cycles at y = 79.
  - x = 0..7 are COLOR_ON (110); x = 8..15 are COLOR_OFF (000); the pattern repeats.
- After one tick with dir = 0:
  - The second pass has x = 0..6 ON, x = 7..14 OFF, x = 15 ON (phase = 1).
- dir = 1 from reset, one tick:
  - phase = 15, so x = 0 is OFF and x = 1..8 are ON.
- BAR_STEP_TICKS = 2, BAR_H = 5:
  - After the 2nd tick, ERASE plots 5 pixels at (0, 0..4) with colour 000.
  - Then bar_level = 1, followed by a DRAW pass.
- BAR_W = 3:
  - After 3 ERASE visits, bar_empty = 1.
  - Later step ticks go straight to DRAW with no ERASE.
  - A refill pulse sets bar_level = 0 and bar_empty = 0.
- NUM_ROWS = 2, ROW_STEP = 2, ROW_SKEW = 4:
  - A pass lasts 320 cycles; row 1 is at y = 81 with x = 0..3 ON.
- Reset pulse at cycle 50 of a pass:
  - The next edge shows plot = 0 and all outputs at reset values.
  - After release, the first plot comes only once enable = 1 moves the FSM from IDLE into DRAW (one edge after release), starting at x = 0.
